mips_timer: RTL and testbench
=============================

// Module: mips_timer
// PURPOSE
//  Memory-mapped down-counting timer; one of the interrupt sources feeding the P7 MIPS system top.
//  Sits behind the system bus bridge. The CPU programs it with sw/lw.
//  Drives one interrupt line into the CP0 hardware-interrupt inputs.
// PARAMETERS
//  DATA_W   32  width of bus data, PRESET and COUNT
//  PRESC_W  3   width of CTRL.PRESC field (only used with TIMER_PRESCALE_EN)
// PORTS
//  clk    in   1       system clock, all logic on rising edge
//  reset  in   1       synchronous, active-low (0 = reset)
//  addr   in   2       word offset addr[3:2]: 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved
//  we     in   1       bus write strobe, one cycle per write
//  din    in   DATA_W  bus write data
//  dout   out  DATA_W  combinational read data for addr; reserved reads 0
//  irq    out  1       interrupt request to CP0, registered
// BEHAVIOUR
//  Reset (reset==0 at an edge) clears all of the following:
//   - CTRL, PRESET, COUNT, irq_pending; state=IDLE
//   - so dout reads 0 and irq=0
//  Reset mid-count aborts the count immediately. Bus writes in the reset cycle are ignored.
//  CTRL register bits:
//   - [0] EN: counter enable
//   - [2:1] MODE: 00 one-shot, 01 auto-reload, 1x treated as 00
//   - [3] IM: interrupt mask
//   - others read 0
//  Register writes:
//   - Writing CTRL commits at that edge and clears irq_pending.
//   - Writing PRESET takes effect at the next LOAD, never mid-count.
//   - Writes to COUNT and to reserved are ignored.
//  FSM states, all in the registered state:
//   - IDLE: go to LOAD when EN==1.
//   - LOAD: COUNT<=PRESET, go to CNT.
//   - CNT: if EN==0, go to IDLE and hold COUNT. Else if COUNT!=0, COUNT<=COUNT-1. Else go to INT.
//   - INT: set irq_pending. MODE00: clear EN, go to IDLE. MODE01: go to LOAD.
//  irq = irq_pending & IM.
//   - MODE00: irq_pending holds until a CTRL write or reset.
//   - MODE01: irq_pending is set in INT and cleared automatically when LOAD completes, so irq is a 1-cycle pulse per period.
//  Latency, PRESET=N, EN written at edge e0:
//   - LOAD at e1
//   - COUNT==N after e2
//   - COUNT==0 after e(2+N)
//   - irq high after e(4+N); period in MODE01 = N+3 cycles
//  Boundaries:
//   - PRESET=0 gives irq after e4.
//   - COUNT never wraps below 0.
//   - A CTRL write in the same cycle as the FSM clearing EN in INT: the bus write wins.
//   - Clearing EN mid-count freezes COUNT; re-enabling restarts from LOAD.
// CONFIGURATION
//  Macro TIMER_PRESCALE_EN.
//  When defined:
//   - CTRL[4+:PRESC_W] = PRESC.
//   - CNT decrements only on tick, one tick every 2^PRESC clocks.
//   - The divider restarts at LOAD.
//   - PRESC=0 gives behaviour identical to the macro being undefined.
//  When undefined:
//   - the bits read 0 and writes to them are ignored
//   - decrement happens every cycle in CNT
// STRUCTURE
//  Shared header timer_defs.vh holds:
//   - register offsets (CTRL/PRESET/COUNT)
//   - CTRL bit positions
//   - MODE encodings
//   - FSM state encodings (IDLE, LOAD, CNT, INT)
//  Sub-module timer_prescaler (tick generator with sync clear) exists only under TIMER_PRESCALE_EN.
//  The rest is one always block for registers/FSM plus a combinational read mux.
// TESTING
//  Reset and read-back:
//   - hold reset=0 for 3 cycles, then read CTRL/PRESET/COUNT -> all 0, irq=0
//   - write PRESET=5 -> reads 5
//   - write COUNT=9 -> COUNT still reads 0
//  One-shot:
//   - PRESET=5, CTRL=0b1001 at e0 -> irq=1 after e9
//   - then CTRL.EN reads 0 and COUNT=0
//   - irq stays 1 until a CTRL write of 0, then irq=0 the next cycle
//  Auto-reload:
//   - PRESET=3, CTRL=0b1011 -> 1-cycle irq pulses every 6 cycles
//   - count 5 pulses, then write EN=0 -> no further pulses, COUNT frozen
//  Masking and edge values:
//   - IM=0, MODE00, PRESET=2 -> irq stays 0 but INT is still reached (EN clears)
//   - PRESET=0 -> irq after e4
//  Reset mid-count:
//   - PRESET=100, enabled; at COUNT=50 drive reset=0 one cycle -> all registers 0, irq=0, state IDLE
//   - PRESET write during counting -> current period unchanged, new value used at next reload
//  Prescaler (macro on):
//   - PRESC=2, PRESET=2, one-shot -> COUNT steps every 4 cycles
//   - irq after e12: e2 LOAD, +2 ticks x4 cycles, +INT, with divider alignment checked

Source files
------------

// File: rtl/mips_timer_pkg.sv
// Shared definitions for the mips_timer block: register offsets, CTRL bit
// positions, MODE encodings and FSM state encodings.
package mips_timer_pkg;

    // Word offsets on addr[3:2]
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    // CTRL bit positions
    localparam int CTRL_EN        = 0;
    localparam int CTRL_MODE_LSB  = 1;
    localparam int CTRL_IM        = 3;
    localparam int CTRL_PRESC_LSB = 4;

    // MODE encodings; 1x behaves as one-shot
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_e;

    // Only the exact 01 encoding reloads; everything else is one-shot.
    function automatic logic is_reload(input logic [1:0] mode);
        return mode == MODE_RELOAD;
    endfunction

endpackage

// File: rtl/mips_timer_prescaler.sv
// Tick generator for mips_timer: one tick every 2^presc clocks, counted from
// the last synchronous clear. Only built when TIMER_PRESCALE_EN is defined.
`ifdef TIMER_PRESCALE_EN
module timer_prescaler #(
    parameter int PRESC_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    // Wide enough for the largest divide ratio 2^(2^PRESC_W - 1)
    localparam int DIV_W = (1 << PRESC_W) - 1;

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic [DIV_W-1:0] lim;

    // Low-bit mask selecting the active divider bits; the divider is a plain
    // up-counter so ticks land on multiples of 2^presc since the last clear,
    // even if presc changes mid-count.
    always_comb begin
        lim = '0;
        for (int i = 0; i < DIV_W; i++) begin
            lim[i] = (i < int'(presc));
        end
        tick  = ((div_q & lim) == lim);
        div_d = clr ? '0 : div_q + DIV_W'(1);
    end

    // Divider register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule
`endif

// File: rtl/mips_timer.sv
// Memory-mapped down-counting timer with one interrupt line to CP0.
// Optional feature macro: TIMER_PRESCALE_EN adds CTRL.PRESC and a clock
// divider gating the decrement; without it the counter steps every cycle.
module mips_timer
    import mips_timer_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int PRESC_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        addr,
    input  logic              we,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              irq
);

    if (PRESC_W < 1 || PRESC_W > 5 || DATA_W < 8) begin : g_bad_param
        $error("mips_timer: PRESC_W must be 1..5 and DATA_W at least 8");
    end

`ifdef TIMER_PRESCALE_EN
    localparam int CTRL_BITS = CTRL_PRESC_LSB + PRESC_W;
`else
    localparam int CTRL_BITS = CTRL_PRESC_LSB;
`endif
    // Writable CTRL bits; everything above reads back 0
    localparam logic [DATA_W-1:0] CTRL_MASK = DATA_W'((64'd1 << CTRL_BITS) - 64'd1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] preset_q, preset_d;
    logic [DATA_W-1:0] count_q, count_d;
    logic              pend_q, pend_d;
    logic              tick;

`ifdef TIMER_PRESCALE_EN
    timer_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk   (clk),
        .reset (reset),
        .clr   (state_q == ST_LOAD),
        .presc (ctrl_q[CTRL_PRESC_LSB +: PRESC_W]),
        .tick  (tick)
    );
`else
    assign tick = 1'b1;
`endif

    // Next-state logic: FSM first, then bus writes so a CTRL write overrides
    // the FSM clearing EN / setting irq_pending in the same cycle.
    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        pend_d   = pend_q;

        case (state_q)
            ST_IDLE: begin
                if (ctrl_q[CTRL_EN]) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                count_d = preset_q;
                pend_d  = 1'b0;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q[CTRL_EN]) begin
                    state_d = ST_IDLE;
                end else if (count_q != '0) begin
                    if (tick) count_d = count_q - DATA_W'(1);
                end else begin
                    state_d = ST_INT;
                end
            end
            ST_INT: begin
                pend_d = 1'b1;
                if (is_reload(ctrl_q[CTRL_MODE_LSB +: 2])) begin
                    state_d = ST_LOAD;
                end else begin
                    ctrl_d[CTRL_EN] = 1'b0;
                    state_d         = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (we) begin
            case (addr)
                ADDR_CTRL: begin
                    ctrl_d = din & CTRL_MASK;
                    pend_d = 1'b0;
                end
                ADDR_PRESET: preset_d = din;
                default: ;
            endcase
        end
    end

    // State and register flops; reset also discards any bus write that cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
        end
    end

    // Combinational read mux; reserved offset reads 0
    always_comb begin
        case (addr)
            ADDR_CTRL:   dout = ctrl_q;
            ADDR_PRESET: dout = preset_q;
            ADDR_COUNT:  dout = count_q;
            default:     dout = '0;
        endcase
    end

    assign irq = pend_q & ctrl_q[CTRL_IM];

endmodule

// File: tb/tb_mips_timer.sv
// Self-checking bench for mips_timer: vector table, hand-written corner
// sequences and a randomized run against a behavioural model.
module tb_mips_timer;

    localparam logic [1:0] A_CTRL = 2'd0, A_PRE = 2'd1, A_CNT = 2'd2, A_RSV = 2'd3;
`ifdef TIMER_PRESCALE_EN
    localparam logic [31:0] WMASK = 32'h0000_007F;
`else
    localparam logic [31:0] WMASK = 32'h0000_000F;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  addr = '0;
    logic        we = 1'b0;
    logic [31:0] din = '0;
    logic [31:0] dout;
    logic        irq;

    int checks = 0;
    int errors = 0;

    mips_timer #(.DATA_W(32), .PRESC_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .din   (din),
        .dout  (dout),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        w;
        logic [1:0]  a;
        logic [31:0] d;
        logic [1:0]  ra;
        logic [31:0] ed;
        logic        ei;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic w, logic [1:0] a, logic [31:0] d,
                                logic [1:0] ra, logic [31:0] ed, logic ei);
        vec_t v;
        v.r = r; v.w = w; v.a = a; v.d = d; v.ra = ra; v.ed = ed; v.ei = ei;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, let the edge happen, then set the read address
    task automatic step(input logic r, input logic w, input logic [1:0] a,
                        input logic [31:0] d, input logic [1:0] ra);
        @(negedge clk);
        reset = r; we = w; addr = a; din = d;
        @(posedge clk);
        #1;
        reset = 1'b1; we = 1'b0; din = '0; addr = ra;
        #1;
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, A_CTRL, 32'h0, A_CTRL);
    endtask

    // ---------------- behavioural reference model ----------------
    // Phase: 0 idle, 1 about to load, 2 counting, 3 expiry.
    logic [31:0] m_ctrl, m_preset, m_count;
    logic        m_pend;
    int          m_ph;
    int unsigned m_since;

    function automatic int m_presc();
`ifdef TIMER_PRESCALE_EN
        return int'((m_ctrl >> 4) & 32'h7);
`else
        return 0;
`endif
    endfunction

    task automatic mdl_edge(input logic r, input logic w, input logic [1:0] a, input logic [31:0] d);
        logic [31:0] c, p, cnt;
        logic        pend;
        int          ph;
        int unsigned since;
        int unsigned period;
        if (!r) begin
            m_ctrl = 0; m_preset = 0; m_count = 0; m_pend = 0; m_ph = 0; m_since = 0;
            return;
        end
        c = m_ctrl; p = m_preset; cnt = m_count; pend = m_pend; ph = m_ph;
        since = m_since + 1;
        period = 32'd1 << m_presc();
        if (m_ph == 0) begin
            if (m_ctrl[0]) ph = 1;
        end else if (m_ph == 1) begin
            cnt = m_preset; pend = 0; since = 0; ph = 2;
        end else if (m_ph == 2) begin
            if (!m_ctrl[0]) ph = 0;
            else if (m_count == 0) ph = 3;
            else if ((m_since % period) == period - 1) cnt = m_count - 1;
        end else begin
            pend = 1;
            if (m_ctrl[2:1] == 2'b01) ph = 1;
            else begin c[0] = 1'b0; ph = 0; end
        end
        if (w && a == A_CTRL) begin c = d & WMASK; pend = 0; end
        if (w && a == A_PRE) p = d;
        m_ctrl = c; m_preset = p; m_count = cnt; m_pend = pend; m_ph = ph; m_since = since;
    endtask

    function automatic logic [31:0] mdl_read(input logic [1:0] a);
        case (a)
            A_CTRL:  return m_ctrl;
            A_PRE:   return m_preset;
            A_CNT:   return m_count;
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        reset = 1'b0;

        // ---------------- table: reset, read-back, one-shot ----------------
        tbl.push_back(mk(0, 0, A_CTRL, 0,            A_CTRL, 0, 0));
        tbl.push_back(mk(0, 1, A_PRE,  7,            A_PRE,  0, 0));
        tbl.push_back(mk(0, 0, A_CTRL, 0,            A_CNT,  0, 0));
        tbl.push_back(mk(1, 0, A_CTRL, 0,            A_CTRL, 0, 0));
        tbl.push_back(mk(1, 1, A_PRE,  5,            A_PRE,  5, 0));
        tbl.push_back(mk(1, 1, A_CNT,  9,            A_CNT,  0, 0));
        tbl.push_back(mk(1, 1, A_RSV,  32'hFFFF,     A_RSV,  0, 0));
        tbl.push_back(mk(1, 1, A_CTRL, 32'hFFFFFF00, A_CTRL, 0, 0));
        tbl.push_back(mk(1, 1, A_CTRL, 32'h9,        A_CTRL, 9, 0));   // e0
        tbl.push_back(mk(1, 0, A_CTRL, 0,            A_CNT,  0, 0));   // e1 LOAD
        tbl.push_back(mk(1, 0, A_CTRL, 0,            A_CNT,  5, 0));   // e2
        tbl.push_back(mk(1, 0, A_CTRL, 0,            A_CNT,  4, 0));
        tbl.push_back(mk(1, 0, A_CTRL, 0,            A_CNT,  3, 0));
        tbl.push_back(mk(1, 0, A_CTRL, 0,            A_CNT,  2, 0));
        tbl.push_back(mk(1, 0, A_CTRL, 0,            A_CNT,  1, 0));
        tbl.push_back(mk(1, 0, A_CTRL, 0,            A_CNT,  0, 0));   // e7
        tbl.push_back(mk(1, 0, A_CTRL, 0,            A_CNT,  0, 0));   // e8 INT
        tbl.push_back(mk(1, 0, A_CTRL, 0,            A_CTRL, 8, 1));   // e9
        tbl.push_back(mk(1, 0, A_CTRL, 0,            A_CNT,  0, 1));
        tbl.push_back(mk(1, 0, A_CTRL, 0,            A_PRE,  5, 1));
        tbl.push_back(mk(1, 1, A_CTRL, 0,            A_CTRL, 0, 0));
        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].ra);
            chk($sformatf("vec%0d_dout", i), dout, tbl[i].ed);
            chk($sformatf("vec%0d_irq", i), {31'b0, irq}, {31'b0, tbl[i].ei});
        end

        // ---------------- auto-reload: PRESET=3, pulses every 6 ----------------
        do_reset();
        step(1, 1, A_PRE, 3, A_CNT);
        step(1, 1, A_CTRL, 32'hB, A_CNT);                 // e0
        for (int k = 1; k <= 32; k++) begin
            step(1, 0, A_CTRL, 0, A_CNT);
            chk($sformatf("reload_irq_e%0d", k), {31'b0, irq},
                {31'b0, (k >= 7 && ((k - 7) % 6) == 0)});
        end
        step(1, 1, A_CTRL, 32'hA, A_CNT);                 // e33 EN=0
        chk("reload_stop_count", dout, 2);
        for (int k = 0; k < 15; k++) begin
            step(1, 0, A_CTRL, 0, A_CNT);
            chk("reload_stop_irq", {31'b0, irq}, 0);
            chk("reload_frozen_count", dout, 2);
        end

        // ---------------- masked one-shot: INT still clears EN ----------------
        do_reset();
        step(1, 1, A_PRE, 2, A_CTRL);
        step(1, 1, A_CTRL, 32'h1, A_CTRL);
        for (int k = 1; k <= 8; k++) begin
            step(1, 0, A_CTRL, 0, A_CTRL);
            chk("masked_irq", {31'b0, irq}, 0);
        end
        chk("masked_en_cleared", dout, 0);

        // ---------------- PRESET=0: irq after e4 ----------------
        do_reset();
        step(1, 1, A_PRE, 0, A_CTRL);
        step(1, 1, A_CTRL, 32'h9, A_CTRL);
        for (int k = 1; k <= 6; k++) begin
            step(1, 0, A_CTRL, 0, A_CNT);
            chk($sformatf("preset0_irq_e%0d", k), {31'b0, irq}, {31'b0, k >= 4});
        end

        // ---------------- CTRL write in the INT cycle wins ----------------
        do_reset();
        step(1, 1, A_PRE, 0, A_CTRL);
        step(1, 1, A_CTRL, 32'h9, A_CTRL);
        for (int k = 1; k <= 3; k++) step(1, 0, A_CTRL, 0, A_CTRL);
        step(1, 1, A_CTRL, 32'h9, A_CTRL);                // e4, INT cycle
        chk("bus_wins_ctrl", dout, 9);
        chk("bus_wins_irq", {31'b0, irq}, 0);

        // ---------------- reset mid-count ----------------
        do_reset();
        step(1, 1, A_PRE, 100, A_CNT);
        step(1, 1, A_CTRL, 32'h9, A_CNT);
        for (int k = 1; k <= 52; k++) step(1, 0, A_CTRL, 0, A_CNT);
        chk("midreset_count50", dout, 50);
        step(0, 1, A_PRE, 7, A_CTRL);
        chk("midreset_ctrl", dout, 0);
        chk("midreset_irq", {31'b0, irq}, 0);
        addr = A_PRE; #1;
        chk("midreset_preset", dout, 0);
        for (int k = 0; k < 4; k++) begin
            step(1, 0, A_CTRL, 0, A_CNT);
            chk("midreset_idle_count", dout, 0);
        end

        // ---------------- PRESET write mid-count ----------------
        do_reset();
        step(1, 1, A_PRE, 4, A_CNT);
        step(1, 1, A_CTRL, 32'hB, A_CNT);                 // e0
        for (int k = 1; k <= 14; k++) begin
            if (k == 4) step(1, 1, A_PRE, 1, A_CNT);
            else step(1, 0, A_CTRL, 0, A_CNT);
            chk($sformatf("newpreset_irq_e%0d", k), {31'b0, irq}, {31'b0, (k == 8 || k == 12)});
        end

`ifdef TIMER_PRESCALE_EN
        // ---------------- prescaler: PRESC=2, PRESET=2 ----------------
        do_reset();
        step(1, 1, A_PRE, 2, A_CNT);
        step(1, 1, A_CTRL, 32'h29, A_CNT);                // e0
        for (int k = 1; k <= 13; k++) begin
            int exp_c;
            step(1, 0, A_CTRL, 0, A_CNT);
            exp_c = (k < 2) ? 0 : (k < 6) ? 2 : (k < 10) ? 1 : 0;
            chk($sformatf("presc_count_e%0d", k), dout, exp_c);
            chk($sformatf("presc_irq_e%0d", k), {31'b0, irq}, {31'b0, k >= 12});
        end
`endif

        // ---------------- randomized run against the model ----------------
        do_reset();
        mdl_edge(0, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            logic        r, w;
            logic [1:0]  a, ra;
            logic [31:0] d;
            r  = ($urandom_range(0, 299) != 0);
            w  = ($urandom_range(0, 5) == 0);
            a  = 2'($urandom_range(0, 3));
            ra = 2'($urandom_range(0, 3));
            d  = (a == A_PRE) ? 32'($urandom_range(0, 6)) : $urandom;
            if (a == A_CTRL && $urandom_range(0, 1) == 1) d = d & 32'hFFFF_FF1F;
            step(r, w, a, d, ra);
            mdl_edge(r, w, a, d);
            chk("rand_dout", dout, mdl_read(ra));
            chk("rand_irq", {31'b0, irq}, {31'b0, m_pend & m_ctrl[3]});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
